// File: rtl/arch_defs_pkg.sv
// Shared flag indices, flag-op encoding and flag-merge helper for the status flags unit.
package arch_defs_pkg;

    localparam int unsigned NUM_FLAGS = 4;
    localparam int unsigned FLAG_Z    = 0;
    localparam int unsigned FLAG_C    = 1;
    localparam int unsigned FLAG_N    = 2;
    localparam int unsigned FLAG_V    = 3;
    localparam int unsigned OP_WIDTH  = 3;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    typedef enum logic [OP_WIDTH-1:0] {
        NONE    = 3'd0,
        ALU     = 3'd1,
        LOAD    = 3'd2,
        RESTORE = 3'd3,
        SEC     = 3'd4,
        CLC     = 3'd5,
        PUSH    = 3'd6,
        POP     = 3'd7
    } flag_op_e;

    // LOAD may only touch Z and N; C and V are not derivable from a bus value.
    localparam flags_t LOAD_MASK = flags_t'((1 << FLAG_Z) | (1 << FLAG_N));

    function automatic flags_t merge_flags(input flags_t cur, input flags_t cand, input flags_t mask);
        return (cur & ~mask) | (cand & mask);
    endfunction

endpackage

// File: rtl/flag_shadow_stack.sv
// Parametrised LIFO used to save/restore flag images; saturating pointer, no wrap-around.
module flag_shadow_stack
    import arch_defs_pkg::*;
#(
    parameter int unsigned WIDTH = NUM_FLAGS,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout_c,
    output logic [CW-1:0]    count,
    output logic             full_c,
    output logic             empty_c,
    output logic             overflow_c,
    output logic             underflow_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);

    // Push takes priority should a caller ever raise both strobes together.
    assign wr_en       = push && !full_c;
    assign rd_en       = pop && !push && !empty_c;
    assign overflow_c  = push && full_c;
    assign underflow_c = pop && !push && empty_c;

    assign dout_c = empty_c ? '0 : mem[AW'(count - CW'(1))];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + CW'(1);
        end else if (rd_en) begin
            count <= count - CW'(1);
        end
    end

    // Storage is not reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[AW'(count)] <= din;
        end
    end

endmodule

// File: rtl/status_flags_unit.sv
// Z/C/N/V condition-flag register with masked updates, set/clear ops and a LIFO shadow stack.
module status_flags_unit
    import arch_defs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned CNT_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  flag_op_e              op,
    input  logic [NUM_FLAGS-1:0]  flag_mask,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  clear_err,
    output logic [NUM_FLAGS-1:0]  flags_o,
    output logic                  flag_zero_o,
    output logic                  flag_carry_o,
    output logic                  flag_negative_o,
    output logic                  flag_overflow_o,
    output logic [CNT_W-1:0]      stack_count,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_err
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    flags_t flags_next;
    flags_t alu_cand;
    flags_t load_cand;
    flags_t stack_top;
    logic   push_req;
    logic   pop_req;
    logic   overflow;
    logic   underflow;
    logic   err_next;

    flag_shadow_stack #(
        .WIDTH (NUM_FLAGS),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push        (push_req),
        .pop         (pop_req),
        .din         (flags_o),
        .dout_c      (stack_top),
        .count       (stack_count),
        .full_c      (stack_full),
        .empty_c     (stack_empty),
        .overflow_c  (overflow),
        .underflow_c (underflow)
    );

    // Next-flag selection; ops are mutually exclusive so no priority is needed.
    always_comb begin
        flags_next = flags_o;
        push_req   = 1'b0;
        pop_req    = 1'b0;
        alu_cand   = '0;
        load_cand  = '0;

        alu_cand[FLAG_Z]  = (alu_result == '0);
        alu_cand[FLAG_C]  = alu_carry;
        alu_cand[FLAG_N]  = alu_result[MSB];
        alu_cand[FLAG_V]  = alu_overflow;
        load_cand[FLAG_Z] = (bus_in == '0);
        load_cand[FLAG_N] = bus_in[MSB];

        case (op)
            ALU:     flags_next = merge_flags(flags_o, alu_cand, flag_mask);
            LOAD:    flags_next = merge_flags(flags_o, load_cand, flag_mask & LOAD_MASK);
            RESTORE: flags_next = merge_flags(flags_o, bus_in[NUM_FLAGS-1:0], flag_mask);
            SEC:     flags_next[FLAG_C] = 1'b1;
            CLC:     flags_next[FLAG_C] = 1'b0;
            PUSH:    push_req = 1'b1;
            POP: begin
                pop_req = 1'b1;
                if (!stack_empty) begin
                    flags_next = stack_top;
                end
            end
            default: flags_next = flags_o;
        endcase
    end

    // A fresh stack error in the same cycle outranks clear_err.
    always_comb begin
        err_next = stack_err;
        if (overflow || underflow) begin
            err_next = 1'b1;
        end else if (clear_err) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_o   <= '0;
            stack_err <= 1'b0;
        end else begin
            flags_o   <= flags_next;
            stack_err <= err_next;
        end
    end

    assign flag_zero_o     = flags_o[FLAG_Z];
    assign flag_carry_o    = flags_o[FLAG_C];
    assign flag_negative_o = flags_o[FLAG_N];
    assign flag_overflow_o = flags_o[FLAG_V];

endmodule
